// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    input  dmem_req_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    output dmem_req_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns the EM register into data-memory
// transactions and produces the MW register, stalling upstream while busy.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              EM_valid,
  input  logic [31:0]       EM_pc,
  input  logic [31:0]       EM_alu_result,
  input  logic [31:0]       EM_w_data,
  input  logic [1:0]        EM_mem_access_width,
  input  logic [4:0]        EM_rd_addr,
  input  logic              EM_w_enable,
  input  logic              EM_is_store,
  input  logic              EM_is_load,
  input  logic              EM_is_load_unsigned,
  output logic              stall,
  mem_access_if.master      dmem,
  output logic              MW_valid,
  output logic [31:0]       MW_pc,
  output logic [4:0]        MW_rd_addr,
  output logic              MW_w_enable,
  output logic [31:0]       MW_w_data,
  output logic              MW_misaligned,
  output logic              MW_bus_error
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  width_q, width_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        wen_q, wen_d;

  logic        mw_valid_q, mw_valid_d;
  logic [31:0] mw_pc_q, mw_pc_d;
  logic [4:0]  mw_rd_q, mw_rd_d;
  logic        mw_wen_q, mw_wen_d;
  logic [31:0] mw_wdata_q, mw_wdata_d;
  logic        mw_mis_q, mw_mis_d;
  logic        mw_berr_q, mw_berr_d;

  logic        em_mem, em_misaligned;
  logic [3:0]  em_be;
  logic [31:0] em_wdata;
  logic [31:0] load_shift, load_data;

  assign em_mem = EM_is_load | EM_is_store;

  always_comb begin
    em_misaligned = 1'b0;
    em_be         = 4'b0000;
    em_wdata      = 32'h0;
    case (EM_mem_access_width)
      2'd0: begin
        em_be    = 4'b0001 << EM_alu_result[1:0];
        em_wdata = {4{EM_w_data[7:0]}};
      end
      2'd1: begin
        em_misaligned = EM_alu_result[0];
        em_be         = 4'b0011 << EM_alu_result[1:0];
        em_wdata      = {2{EM_w_data[15:0]}};
      end
      2'd2: begin
        em_misaligned = |EM_alu_result[1:0];
        em_be         = 4'b1111;
        em_wdata      = EM_w_data;
      end
      default: em_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    load_shift = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
    case (width_q)
      2'd0:    load_data = {{24{load_shift[7] & ~unsigned_q}}, load_shift[7:0]};
      2'd1:    load_data = {{16{load_shift[15] & ~unsigned_q}}, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    width_d    = width_q;
    unsigned_d = unsigned_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    // MW flags default low so errors last exactly one MW update.
    mw_valid_d = 1'b0;
    mw_pc_d    = mw_pc_q;
    mw_rd_d    = mw_rd_q;
    mw_wen_d   = 1'b0;
    mw_wdata_d = mw_wdata_q;
    mw_mis_d   = 1'b0;
    mw_berr_d  = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (EM_valid) begin
          if (!em_mem) begin
            mw_valid_d = 1'b1;
            mw_pc_d    = EM_pc;
            mw_rd_d    = EM_rd_addr;
            mw_wen_d   = EM_w_enable & (|EM_rd_addr);
            mw_wdata_d = EM_alu_result;
          end else if (em_misaligned) begin
            mw_valid_d = 1'b1;
            mw_pc_d    = EM_pc;
            mw_rd_d    = EM_rd_addr;
            mw_wdata_d = 32'h0;
            mw_mis_d   = 1'b1;
          end else begin
            stall      = 1'b1;
            addr_d     = EM_alu_result;
            be_d       = em_be;
            wdata_d    = em_wdata;
            we_d       = EM_is_store;
            width_d    = EM_mem_access_width;
            unsigned_d = EM_is_load_unsigned;
            pc_d       = EM_pc;
            rd_d       = EM_rd_addr;
            wen_d      = EM_w_enable;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        stall = 1'b1;
        if (dmem.dmem_req_ready) begin
          if (we_q) begin
            stall      = 1'b0;
            mw_valid_d = 1'b1;
            mw_pc_d    = pc_q;
            mw_rd_d    = rd_q;
            mw_wdata_d = 32'h0;
            state_d    = StIdle;
          end else begin
            cnt_d   = 16'h0;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (dmem.dmem_rvalid || cnt_q == CntLast) begin
          stall      = 1'b0;
          mw_valid_d = 1'b1;
          mw_pc_d    = pc_q;
          mw_rd_d    = rd_q;
          state_d    = StIdle;
          if (dmem.dmem_rvalid) begin
            mw_wen_d   = wen_q & (|rd_q);
            mw_wdata_d = load_data;
          end else begin
            mw_wdata_d = 32'h0;
            mw_berr_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      state_q    <= StIdle;
      cnt_q      <= 16'h0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      width_q    <= 2'd0;
      unsigned_q <= 1'b0;
      pc_q       <= 32'h0;
      rd_q       <= 5'd0;
      wen_q      <= 1'b0;
      mw_valid_q <= 1'b0;
      mw_pc_q    <= 32'h0;
      mw_rd_q    <= 5'd0;
      mw_wen_q   <= 1'b0;
      mw_wdata_q <= 32'h0;
      mw_mis_q   <= 1'b0;
      mw_berr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      width_q    <= width_d;
      unsigned_q <= unsigned_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      mw_valid_q <= mw_valid_d;
      mw_pc_q    <= mw_pc_d;
      mw_rd_q    <= mw_rd_d;
      mw_wen_q   <= mw_wen_d;
      mw_wdata_q <= mw_wdata_d;
      mw_mis_q   <= mw_mis_d;
      mw_berr_q  <= mw_berr_d;
    end
  end

  assign dmem.dmem_req_valid = (state_q == StReq);
  assign dmem.dmem_addr      = {addr_q[31:2], 2'b00};
  assign dmem.dmem_we        = we_q;
  assign dmem.dmem_be        = be_q;
  assign dmem.dmem_wdata     = wdata_q;

  assign MW_valid      = mw_valid_q;
  assign MW_pc         = mw_pc_q;
  assign MW_rd_addr    = mw_rd_q;
  assign MW_w_enable   = mw_wen_q;
  assign MW_w_data     = mw_wdata_q;
  assign MW_misaligned = mw_mis_q;
  assign MW_bus_error  = mw_berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: inputs driven on the falling edge, outputs
// checked 1 time unit later, expected values hand-computed.
module tb_mem_access;
  logic        clk, rstd;
  logic        EM_valid, EM_w_enable, EM_is_store, EM_is_load, EM_is_load_unsigned;
  logic [31:0] EM_pc, EM_alu_result, EM_w_data;
  logic [1:0]  EM_mem_access_width;
  logic [4:0]  EM_rd_addr;
  logic        stall;
  logic        MW_valid, MW_w_enable, MW_misaligned, MW_bus_error;
  logic [31:0] MW_pc, MW_w_data;
  logic [4:0]  MW_rd_addr;
  int          n_tests, n_fail;

  mem_access_if dmem_bus ();

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .rstd                (rstd),
    .EM_valid            (EM_valid),
    .EM_pc               (EM_pc),
    .EM_alu_result       (EM_alu_result),
    .EM_w_data           (EM_w_data),
    .EM_mem_access_width (EM_mem_access_width),
    .EM_rd_addr          (EM_rd_addr),
    .EM_w_enable         (EM_w_enable),
    .EM_is_store         (EM_is_store),
    .EM_is_load          (EM_is_load),
    .EM_is_load_unsigned (EM_is_load_unsigned),
    .stall               (stall),
    .dmem                (dmem_bus),
    .MW_valid            (MW_valid),
    .MW_pc               (MW_pc),
    .MW_rd_addr          (MW_rd_addr),
    .MW_w_enable         (MW_w_enable),
    .MW_w_data           (MW_w_data),
    .MW_misaligned       (MW_misaligned),
    .MW_bus_error        (MW_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_em(input logic v, input logic ld, input logic st, input logic uns,
                        input logic [1:0] w, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic wen);
    EM_valid = v; EM_is_load = ld; EM_is_store = st; EM_is_load_unsigned = uns;
    EM_mem_access_width = w; EM_pc = pc; EM_alu_result = addr; EM_w_data = data;
    EM_rd_addr = rd; EM_w_enable = wen;
  endtask

  // Advance to the next falling edge and let combinational outputs settle.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstd = 1'b1;
    set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    rstd = 1'b0;
    #1;
    n_tests++; if (MW_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mw_valid: got %b want 0", MW_valid); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if (dmem_bus.dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", dmem_bus.dmem_req_valid); end
    n_tests++; if ({MW_pc, MW_w_data} !== 64'h0) begin n_fail++; $display("FAIL reset_mw_data: got %h want 0", {MW_pc, MW_w_data}); end
  endtask

  task automatic test_alu();
    next_cycle();
    set_em(1, 0, 0, 0, 2'd2, 32'h10, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
    next_cycle();
    set_em(1, 0, 0, 0, 2'd2, 32'h14, 32'h9999, 32'h0, 5'd0, 1'b1);
    #1;
    n_tests++; if ({MW_valid, MW_w_enable, MW_rd_addr} !== {1'b1, 1'b1, 5'd5}) begin n_fail++; $display("FAIL alu_mw_ctrl: got %b%b %0d want 1 1 5", MW_valid, MW_w_enable, MW_rd_addr); end
    n_tests++; if (MW_w_data !== 32'h1234) begin n_fail++; $display("FAIL alu_mw_data: got %h want 00001234", MW_w_data); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall2: got %b want 0", stall); end
    next_cycle();
    set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    n_tests++; if ({MW_valid, MW_w_enable, MW_w_data} !== {1'b1, 1'b0, 32'h9999}) begin n_fail++; $display("FAIL alu_rd0: got %b%b %h want 1 0 00009999", MW_valid, MW_w_enable, MW_w_data); end
    next_cycle();
    n_tests++; if (MW_valid !== 1'b0) begin n_fail++; $display("FAIL alu_idle: got %b want 0", MW_valid); end
  endtask

  task automatic test_store_byte();
    dmem_bus.dmem_req_ready = 1'b1;
    next_cycle();
    set_em(1, 0, 1, 0, 2'd0, 32'h40, 32'h103, 32'h55AB, 5'd0, 1'b0);
    #1;
    n_tests++; if ({stall, dmem_bus.dmem_req_valid} !== 2'b10) begin n_fail++; $display("FAIL st_idle: stall/req got %b%b want 10", stall, dmem_bus.dmem_req_valid); end
    next_cycle();
    // Altered EM fields must not leak into the captured request.
    EM_alu_result = 32'hDEAD0000; EM_w_data = 32'h0;
    #1;
    n_tests++; if (dmem_bus.dmem_req_valid !== 1'b1) begin n_fail++; $display("FAIL st_req_valid: got %b want 1", dmem_bus.dmem_req_valid); end
    n_tests++; if (dmem_bus.dmem_be !== 4'b1000) begin n_fail++; $display("FAIL st_be: got %b want 1000", dmem_bus.dmem_be); end
    n_tests++; if (dmem_bus.dmem_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL st_wdata: got %h want abababab", dmem_bus.dmem_wdata); end
    n_tests++; if ({dmem_bus.dmem_addr, dmem_bus.dmem_we} !== {32'h100, 1'b1}) begin n_fail++; $display("FAIL st_addr: got %h we %b want 00000100 1", dmem_bus.dmem_addr, dmem_bus.dmem_we); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL st_req_stall: got %b want 0", stall); end
    next_cycle();
    set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if ({MW_valid, MW_w_enable, MW_pc} !== {1'b1, 1'b0, 32'h40}) begin n_fail++; $display("FAIL st_mw: got %b%b %h want 1 0 00000040", MW_valid, MW_w_enable, MW_pc); end
    n_tests++; if (dmem_bus.dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL st_done_req: got %b want 0", dmem_bus.dmem_req_valid); end
  endtask

  task automatic test_load_half();
    logic [31:0] exp_data;
    for (int v = 0; v < 2; v++) begin
      exp_data = (v == 0) ? 32'hFFFF8001 : 32'h00008001;
      dmem_bus.dmem_req_ready = 1'b0;
      next_cycle();
      set_em(1, 1, 0, logic'(v), 2'd1, 32'h80, 32'h202, 32'h0, 5'd7, 1'b1);
      #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ldh%0d_idle_stall: got %b want 1", v, stall); end
      // Three REQ cycles without ready; a stray rvalid here must be ignored.
      for (int c = 0; c < 3; c++) begin
        next_cycle();
        dmem_bus.dmem_rvalid = (c == 0); dmem_bus.dmem_rdata = 32'h12345678;
        #1;
        n_tests++; if ({stall, dmem_bus.dmem_req_valid, dmem_bus.dmem_be, dmem_bus.dmem_addr} !== {2'b11, 4'b1100, 32'h200}) begin n_fail++; $display("FAIL ldh%0d_req%0d: stall/req/be/addr got %b%b %b %h want 11 1100 00000200", v, c, stall, dmem_bus.dmem_req_valid, dmem_bus.dmem_be, dmem_bus.dmem_addr); end
      end
      next_cycle();
      dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_req_ready = 1'b1;
      #1;
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ldh%0d_accept_stall: got %b want 1", v, stall); end
      next_cycle();
      dmem_bus.dmem_req_ready = 1'b0;
      #1;
      n_tests++; if ({stall, dmem_bus.dmem_req_valid} !== 2'b10) begin n_fail++; $display("FAIL ldh%0d_resp0: stall/req got %b%b want 10", v, stall, dmem_bus.dmem_req_valid); end
      next_cycle();
      dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h80010000;
      set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
      #1;
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ldh%0d_rvalid_stall: got %b want 0", v, stall); end
      next_cycle();
      dmem_bus.dmem_rvalid = 1'b0;
      n_tests++; if ({MW_valid, MW_w_enable, MW_rd_addr} !== {1'b1, 1'b1, 5'd7}) begin n_fail++; $display("FAIL ldh%0d_mw_ctrl: got %b%b %0d want 1 1 7", v, MW_valid, MW_w_enable, MW_rd_addr); end
      n_tests++; if (MW_w_data !== exp_data) begin n_fail++; $display("FAIL ldh%0d_mw_data: got %h want %h", v, MW_w_data, exp_data); end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  widths [2];
    logic [31:0] addrs [2];
    widths[0] = 2'd2; addrs[0] = 32'h305;
    widths[1] = 2'd3; addrs[1] = 32'h300;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      set_em(1, 1, 0, 0, widths[k], 32'hA0, addrs[k], 32'h0, 5'd9, 1'b1);
      #1;
      n_tests++; if ({stall, dmem_bus.dmem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL mis%0d_stall_req: got %b%b want 00", k, stall, dmem_bus.dmem_req_valid); end
      next_cycle();
      set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
      #1;
      n_tests++; if ({MW_valid, MW_misaligned, MW_w_enable, MW_w_data} !== {3'b110, 32'h0}) begin n_fail++; $display("FAIL mis%0d_mw: valid/mis/wen got %b%b%b data %h want 110 00000000", k, MW_valid, MW_misaligned, MW_w_enable, MW_w_data); end
      n_tests++; if (dmem_bus.dmem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis%0d_no_req: got %b want 0", k, dmem_bus.dmem_req_valid); end
      next_cycle();
      n_tests++; if ({MW_valid, MW_misaligned} !== 2'b00) begin n_fail++; $display("FAIL mis%0d_clear: got %b%b want 00", k, MW_valid, MW_misaligned); end
    end
  endtask

  task automatic test_timeout();
    dmem_bus.dmem_req_ready = 1'b1;
    dmem_bus.dmem_rvalid = 1'b0;
    next_cycle();
    set_em(1, 1, 0, 0, 2'd0, 32'hC0, 32'h10, 32'h0, 5'd4, 1'b1);
    next_cycle();  // REQ, accepted this cycle
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      dmem_bus.dmem_req_ready = 1'b0;
      #1;
      n_tests++; if ({stall, MW_valid} !== {logic'(c != 3), 1'b0}) begin n_fail++; $display("FAIL to_resp%0d: stall/mw_valid got %b%b want %b0", c, stall, MW_valid, c != 3); end
    end
    next_cycle();
    set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
    #1;
    n_tests++; if ({MW_valid, MW_bus_error, MW_w_enable, MW_w_data} !== {3'b110, 32'h0}) begin n_fail++; $display("FAIL to_berr: valid/berr/wen got %b%b%b data %h want 110 00000000", MW_valid, MW_bus_error, MW_w_enable, MW_w_data); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_idle_stall: got %b want 0", stall); end
    next_cycle();
    n_tests++; if ({MW_valid, MW_bus_error} !== 2'b00) begin n_fail++; $display("FAIL to_late_rvalid: got %b%b want 00", MW_valid, MW_bus_error); end
    dmem_bus.dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    dmem_bus.dmem_req_ready = 1'b1;
    next_cycle();
    set_em(1, 1, 0, 0, 2'd2, 32'hE0, 32'h20, 32'h0, 5'd6, 1'b1);
    next_cycle();  // REQ
    next_cycle();  // RESP
    dmem_bus.dmem_req_ready = 1'b0;
    rstd = 1'b1;
    set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    next_cycle();
    rstd = 1'b0;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h0BADF00D;
    #1;
    n_tests++; if ({stall, dmem_bus.dmem_req_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_stall: stall/req got %b%b want 00", stall, dmem_bus.dmem_req_valid); end
    n_tests++; if ({MW_valid, MW_pc, MW_rd_addr, MW_w_enable, MW_w_data, MW_misaligned, MW_bus_error} !== 73'h0) begin n_fail++; $display("FAIL rst_mid_mw: got nonzero MW pc %h data %h", MW_pc, MW_w_data); end
    next_cycle();
    dmem_bus.dmem_rvalid = 1'b0;
    n_tests++; if (MW_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid: got %b want 0", MW_valid); end
  endtask

  task automatic test_back_to_back();
    dmem_bus.dmem_req_ready = 1'b1;
    next_cycle();
    set_em(1, 0, 1, 0, 2'd2, 32'h100, 32'h24, 32'h11223344, 5'd0, 1'b0);
    next_cycle();
    n_tests++; if ({dmem_bus.dmem_be, dmem_bus.dmem_wdata, dmem_bus.dmem_addr} !== {4'b1111, 32'h11223344, 32'h24}) begin n_fail++; $display("FAIL b2b_st: be %b wdata %h addr %h want 1111 11223344 00000024", dmem_bus.dmem_be, dmem_bus.dmem_wdata, dmem_bus.dmem_addr); end
    next_cycle();
    set_em(1, 0, 0, 0, 2'd0, 32'h104, 32'h55, 32'h0, 5'd3, 1'b1);
    #1;
    n_tests++; if ({MW_valid, MW_w_enable, MW_pc, stall} !== {2'b10, 32'h100, 1'b0}) begin n_fail++; $display("FAIL b2b_st_mw: got %b%b %h stall %b want 1 0 00000100 0", MW_valid, MW_w_enable, MW_pc, stall); end
    next_cycle();
    set_em(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    n_tests++; if ({MW_valid, MW_w_enable, MW_w_data, MW_pc} !== {2'b11, 32'h55, 32'h104}) begin n_fail++; $display("FAIL b2b_alu_mw: got %b%b %h %h want 1 1 00000055 00000104", MW_valid, MW_w_enable, MW_w_data, MW_pc); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_alu();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
